// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: shared definitions for the serial frame transmitter,
// the matching receiver and the benches.
//   state_t    - FSM state encoding (3 bits)
//   frame_len  - clocks per complete frame
//   cnt_w      - counter width helper, clog2(n) with a floor of 1
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // start + data + optional parity + stop, each CLKS_PER_BIT clocks long
  function automatic int frame_len(input int dw, input int cpb, input int pe);
    return (2 + dw + pe) * cpb;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts clocks within one serial bit.
//   clk      - clock
//   rst      - synchronous active-low reset
//   restart  - hold the count at 0 (used while the line is idle)
//   bit_end  - high on the last clock of each bit
module serial_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 the count sits at 0 and every clock ends a bit.
  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (restart || bit_end) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame: start(0), DATA_W data bits LSB first, optional even parity, stop(1),
// each held CLKS_PER_BIT clocks.
//   clk        - clock
//   rst        - synchronous active-low reset
//   din        - word to send, sampled on accept
//   din_valid  - din holds a word
//   din_ready  - idle, can accept (decoded from state)
//   tx         - serial line, registered, idles high
//   busy       - frame in progress, registered
//   done       - one-clock pulse after the stop bit, registered
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nx;
  logic [BW-1:0]     bit_cnt;
  logic              par;
  logic              bit_end;

  assign din_ready = (state == IDLE);
  assign shift_nx  = shift >> 1;

  // Timer held at 0 while idle so the start bit gets its full length.
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (din_ready),
    .bit_end (bit_end)
  );

  // tx is loaded one edge ahead with the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          tx   <= 1'b1;
          busy <= 1'b0;
          if (din_valid) begin
            shift   <= din;
            par     <= ^din;
            bit_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shift   <= shift_nx;
              tx      <= shift_nx[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
